csi_packet_rx: RTL

- Parametrised successor to the camera MIPI-style front end. Lane count, pixel width and line-length limit are all configurable.
- Hunts a bit-level sync pattern on a LANES-wide input and locks byte alignment. It then decodes a packet-type byte: frame start, frame end, line start, or long pixel packet carrying a 16-bit word count.
- Emits sync pulses, pixel strobes, pixel data and line-buffer write addresses to the downstream line RAM / HDMI path.
- Adds what the previous block lacked: frame-end decode, header-driven line length, truncation protection and an error flag.

---
 rtl/csi_rx_pkg.sv | 18 +
 rtl/csi_byte_aligner.sv | 53 +++++
 rtl/csi_packet_rx.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/csi_rx_pkg.sv
// Shared constants and FSM state type for the CSI-style packet receiver.
package csi_rx_pkg;

    localparam logic [7:0]  DT_FS        = 8'h00;
    localparam logic [7:0]  DT_FE        = 8'h01;
    localparam logic [7:0]  DT_LS        = 8'h40;
    localparam logic [7:0]  DT_PIX       = 8'h54;
    localparam logic [23:0] SYNC_PAT_DEF = 24'h00001D;

    typedef enum logic [2:0] {
        HUNT,
        HEADER,
        WC_LO,
        WC_HI,
        PAYLOAD
    } state_e;

endpackage

// File: rtl/csi_byte_aligner.sv
// Sync hunt on a LANES-wide bit stream, then byte assembly from consecutive lane words.
module csi_byte_aligner
    import csi_rx_pkg::*;
#(
    parameter int          LANES    = 4,
    parameter logic [23:0] SYNC_PAT = SYNC_PAT_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             hunt_i,
    input  logic [LANES-1:0] data_i,
    output logic             sync_hit_o,
    output logic             byte_valid_o,
    output logic [7:0]       byte_o
);

    localparam int WPB = 8 / LANES;
    localparam int CW  = (WPB > 1) ? $clog2(WPB) : 1;
    localparam int AW  = (LANES < 8) ? 8 - LANES : 1;

    logic [23:0]   sr_q;
    logic [23:0]   win;
    logic [AW-1:0] acc_q;
    logic [CW-1:0] cnt_q;

    assign win          = {sr_q[23-LANES:0], data_i};
    assign sync_hit_o   = hunt_i && (win == SYNC_PAT);
    assign byte_valid_o = !hunt_i && (cnt_q == CW'(WPB - 1));

    if (LANES == 8) begin : g_full
        assign byte_o = data_i;
    end else begin : g_part
        assign byte_o = {acc_q, data_i};
    end

    // Outside HUNT the window is held at zero so packet tail bits never seed a false sync.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sr_q  <= '0;
            acc_q <= '0;
            cnt_q <= '0;
        end else if (hunt_i) begin
            sr_q  <= win;
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= '0;
            acc_q <= byte_o[AW-1:0];
            cnt_q <= byte_valid_o ? '0 : cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/csi_packet_rx.sv
// Packet decoder: header/word-count FSM, pixel assembly and line-address generation.
module csi_packet_rx
    import csi_rx_pkg::*;
#(
    parameter int          LANES     = 4,
    parameter int          PIX_BYTES = 2,
    parameter int          ADDR_W    = 10,
    parameter int          MAX_PIX   = 960,
    parameter logic [23:0] SYNC_PAT  = SYNC_PAT_DEF
) (
    input  logic                   CAM_CLK,
    input  logic                   RESET,
    input  logic [LANES-1:0]       CAM_DATA_i,
    output logic                   VSYNC,
    output logic                   FRAME_END,
    output logic                   HSYNC,
    output logic                   PCLK,
    output logic [8*PIX_BYTES-1:0] DATA_OUT,
    output logic [ADDR_W-1:0]      ADDRA,
    output logic                   LINE_END,
    output logic                   ERR
);

    localparam int PW  = 8 * PIX_BYTES;
    localparam int PQW = (PIX_BYTES > 1) ? PW - 8 : 8;

    state_e         state_q;
    logic [7:0]     wc_lo_q;
    logic [15:0]    left_q;
    logic [15:0]    idx_q;
    logic [PQW-1:0] pix_q;
    logic [1:0]     pb_q;
    logic           drop_q;

    logic        sync_hit, bv;
    logic [7:0]  byte_w;
    logic [15:0] wc;
    logic        wc_bad, pix_done, in_range;
    logic [PW-1:0] pix_n;

    csi_byte_aligner #(.LANES(LANES), .SYNC_PAT(SYNC_PAT)) u_align (
        .clk_i        (CAM_CLK),
        .rst_i        (RESET),
        .hunt_i       (state_q == HUNT),
        .data_i       (CAM_DATA_i),
        .sync_hit_o   (sync_hit),
        .byte_valid_o (bv),
        .byte_o       (byte_w)
    );

    if (PIX_BYTES == 1) begin : g_pb1
        assign pix_n = byte_w;
    end else begin : g_pbn
        assign pix_n = {pix_q, byte_w};
    end

    assign wc       = {byte_w, wc_lo_q};
    assign wc_bad   = (wc == 16'd0) || ((wc % 16'(PIX_BYTES)) != 16'd0);
    assign pix_done = (pb_q == 2'(PIX_BYTES - 1));
    assign in_range = 32'(idx_q) < 32'(MAX_PIX);

    always_ff @(posedge CAM_CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= HUNT;
            wc_lo_q   <= '0;
            left_q    <= '0;
            idx_q     <= '0;
            pix_q     <= '0;
            pb_q      <= '0;
            drop_q    <= 1'b0;
            VSYNC     <= 1'b0;
            FRAME_END <= 1'b0;
            HSYNC     <= 1'b0;
            PCLK      <= 1'b0;
            DATA_OUT  <= '0;
            ADDRA     <= '0;
            LINE_END  <= 1'b0;
            ERR       <= 1'b0;
        end else begin
            VSYNC     <= 1'b0;
            FRAME_END <= 1'b0;
            HSYNC     <= 1'b0;
            PCLK      <= 1'b0;
            LINE_END  <= 1'b0;
            ERR       <= 1'b0;
            case (state_q)
                HUNT: if (sync_hit) state_q <= HEADER;
                HEADER: if (bv) begin
                    state_q <= HUNT;
                    case (byte_w)
                        DT_FS:   begin VSYNC <= 1'b1; ADDRA <= '0; end
                        DT_FE:   FRAME_END <= 1'b1;
                        DT_LS:   begin HSYNC <= 1'b1; ADDRA <= '0; end
                        DT_PIX:  state_q <= WC_LO;
                        default: ERR <= 1'b1;
                    endcase
                end
                WC_LO: if (bv) begin
                    wc_lo_q <= byte_w;
                    state_q <= WC_HI;
                end
                WC_HI: if (bv) begin
                    if (wc_bad) begin
                        ERR     <= 1'b1;
                        state_q <= HUNT;
                    end else begin
                        left_q  <= wc;
                        idx_q   <= '0;
                        pb_q    <= '0;
                        drop_q  <= 1'b0;
                        state_q <= PAYLOAD;
                    end
                end
                PAYLOAD: if (bv) begin
                    pix_q  <= pix_n[PQW-1:0];
                    left_q <= left_q - 16'd1;
                    if (pix_done) begin
                        pb_q <= '0;
                        if (in_range) begin
                            PCLK     <= 1'b1;
                            DATA_OUT <= pix_n;
                            ADDRA    <= idx_q[ADDR_W-1:0];
                        end else if (!drop_q) begin
                            // Only the first overflow pixel of a packet is flagged.
                            ERR    <= 1'b1;
                            drop_q <= 1'b1;
                        end
                        if (idx_q != 16'hFFFF) idx_q <= idx_q + 16'd1;
                    end else begin
                        pb_q <= pb_q + 2'd1;
                    end
                    if (left_q == 16'd1) begin
                        LINE_END <= 1'b1;
                        state_q  <= HUNT;
                    end
                end
                default: state_q <= HUNT;
            endcase
        end
    end

endmodule
